// File: rtl/ilum_pkg.sv
// Shared zone-state encoding and default sizing for the lamp zone arbiter.
package ilum_pkg;
  typedef enum logic [1:0] {
    ZS_OFF  = 2'd0,
    ZS_WAIT = 2'd1,
    ZS_ON   = 2'd2
  } zone_st_e;

  localparam int DEF_N_ZONES = 4;
  localparam int DEF_MAX_ON  = 2;
  localparam int DEF_HOLD_T  = 30000;
endpackage

// File: rtl/rr_arbitro.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping to 0.
// One-hot o_gnt, all zeros when nothing requests.
module rr_arbitro
  import ilum_pkg::*;
#(
  parameter int N  = DEF_N_ZONES,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && (i >= int'(i_ptr)) && i_req[i]) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    // Wrapped half of the search, only reached when nothing at/after the pointer asked.
    for (int i = 0; i < N; i++) begin
      if (!w_found && (i < int'(i_ptr)) && i_req[i]) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arbitro_zonas.sv
// Lamp zone arbiter: per-zone OFF/WAIT/ON FSM with hold timer, at most MAX_ON zones lit,
// one round-robin grant per cycle; lamp rises the cycle after a granted request.
module arbitro_zonas
  import ilum_pkg::*;
#(
  parameter int N_ZONES = DEF_N_ZONES,
  parameter int MAX_ON  = DEF_MAX_ON,
  parameter int HOLD_T  = DEF_HOLD_T
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] req,
  input  logic               force_off,
  output logic [N_ZONES-1:0] lamp,
  output logic [N_ZONES-1:0] waiting,
  output logic               busy
);
  localparam int PW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int CW = $clog2(N_ZONES + 1);
  localparam int TW = $clog2(HOLD_T + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_T);

  logic [N_ZONES-1:0] w_on, w_wait, w_on_nxt, w_wait_nxt;
  logic [N_ZONES-1:0] w_rr_req, w_gnt;
  logic [PW-1:0]      r_ptr, w_ptr_nxt;
  logic [CW-1:0]      w_lit, w_lit_nxt;
  logic               w_gnt_en;
  logic               r_busy;

  always_comb begin
    w_lit = '0;
    for (int i = 0; i < N_ZONES; i++) w_lit = w_lit + CW'(w_on[i]);
  end

  always_comb begin
    w_lit_nxt = '0;
    for (int i = 0; i < N_ZONES; i++) w_lit_nxt = w_lit_nxt + CW'(w_on_nxt[i]);
  end

  // Slots freed this cycle are not visible until the zone's state register has updated.
  assign w_gnt_en = !force_off && (int'(w_lit) < MAX_ON);
  assign w_rr_req = (req & ~w_on) & {N_ZONES{w_gnt_en}};

  rr_arbitro #(
    .N  (N_ZONES),
    .PW (PW)
  ) u_rr (
    .i_req (w_rr_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < N_ZONES; i++) begin
      if (w_gnt[i]) w_ptr_nxt = (i == N_ZONES - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_busy <= (int'(w_lit_nxt) == MAX_ON) && (|w_wait_nxt);
    end
  end

  for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
    zone_st_e      r_st, w_st_nxt;
    logic [TW-1:0] r_tmr, w_tmr_nxt;

    always_comb begin
      w_st_nxt  = r_st;
      w_tmr_nxt = r_tmr;
      if (force_off) begin
        w_st_nxt  = ZS_OFF;
        w_tmr_nxt = '0;
      end else begin
        case (r_st)
          ZS_OFF: begin
            if (w_gnt[g]) begin
              w_st_nxt  = ZS_ON;
              w_tmr_nxt = HOLD_LD;
            end else if (req[g]) begin
              w_st_nxt = ZS_WAIT;
            end
          end
          ZS_WAIT: begin
            if (w_gnt[g]) begin
              w_st_nxt  = ZS_ON;
              w_tmr_nxt = HOLD_LD;
            end else if (!req[g]) begin
              w_st_nxt = ZS_OFF;
            end
          end
          ZS_ON: begin
            if (req[g]) begin
              w_tmr_nxt = HOLD_LD;
            end else if (r_tmr == TW'(1)) begin
              w_st_nxt  = ZS_OFF;
              w_tmr_nxt = '0;
            end else begin
              w_tmr_nxt = r_tmr - TW'(1);
            end
          end
          default: begin
            w_st_nxt  = ZS_OFF;
            w_tmr_nxt = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st  <= ZS_OFF;
        r_tmr <= '0;
      end else begin
        r_st  <= w_st_nxt;
        r_tmr <= w_tmr_nxt;
      end
    end

    assign w_on[g]       = (r_st == ZS_ON);
    assign w_wait[g]     = (r_st == ZS_WAIT);
    assign w_on_nxt[g]   = (w_st_nxt == ZS_ON);
    assign w_wait_nxt[g] = (w_st_nxt == ZS_WAIT);
  end

  assign lamp    = w_on;
  assign waiting = w_wait;
  assign busy    = r_busy;
endmodule

// File: tb/tb_arbitro_zonas.sv
// Bench for arbitro_zonas: expiry-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a random soak.
module tb_arbitro_zonas;
  localparam int N     = 4;
  localparam int MAXON = 2;
  localparam int HOLD  = 8;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         force_off = 1'b0;
  logic [N-1:0] req       = '0;
  logic [N-1:0] lamp, waiting;
  logic         busy;

  always #5 clk = ~clk;

  arbitro_zonas #(
    .N_ZONES (N),
    .MAX_ON  (MAXON),
    .HOLD_T  (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .force_off (force_off),
    .lamp      (lamp),
    .waiting   (waiting),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a lit zone remembers the edge at which it may go dark.
  logic [N-1:0] m_on     = '0;
  logic [N-1:0] m_wait   = '0;
  logic         m_busy   = 1'b0;
  int           m_ptr    = 0;
  int           m_ecnt   = 0;
  int           m_off_at [N];
  int           m_lit, m_g, m_z;
  logic [N-1:0] m_on_n, m_wait_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on   = '0;
      m_wait = '0;
      m_busy = 1'b0;
      m_ptr  = 0;
      m_ecnt = 0;
    end else begin
      m_ecnt++;
      m_lit = $countones(m_on);
      m_g   = -1;
      if (!force_off && m_lit < MAXON) begin
        for (int k = 0; k < N; k++) begin
          m_z = (m_ptr + k) % N;
          if (m_g < 0 && req[m_z] && !m_on[m_z]) m_g = m_z;
        end
      end
      for (int z = 0; z < N; z++) begin
        if (force_off) begin
          m_on_n[z]   = 1'b0;
          m_wait_n[z] = 1'b0;
        end else if (m_on[z]) begin
          m_on_n[z]   = 1'b1;
          m_wait_n[z] = 1'b0;
          if (req[z]) m_off_at[z] = m_ecnt + HOLD;
          else if (m_ecnt >= m_off_at[z]) m_on_n[z] = 1'b0;
        end else if (z == m_g) begin
          m_on_n[z]   = 1'b1;
          m_wait_n[z] = 1'b0;
          m_off_at[z] = m_ecnt + HOLD;
        end else begin
          m_on_n[z]   = 1'b0;
          m_wait_n[z] = req[z];
        end
      end
      if (m_g >= 0) m_ptr = (m_g + 1) % N;
      m_on   = m_on_n;
      m_wait = m_wait_n;
      m_busy = ($countones(m_on) == MAXON) && (m_wait != '0);
    end
  end

  always @(negedge clk) begin
    chk("model_lamp",    int'(lamp),    int'(m_on));
    chk("model_waiting", int'(waiting), int'(m_wait));
    chk("model_busy",    int'(busy),    int'(m_busy));
  end

  task automatic reset_dut(input logic [N-1:0] r);
    @(negedge clk);
    #2;
    rst       = 1'b1;
    req       = r;
    force_off = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int hi, fall, rise, over, lows, highs;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_lamp", int'(lamp), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;

    // Single one-cycle request on zone 0.
    @(negedge clk);
    req = 4'b0001;
    hi  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (lamp == 4'b0001) hi++;
      req = '0;
    end
    chk("pulse_len", hi, HOLD);
    chk("pulse_end", int'(lamp), 0);

    // All zones request from reset release; then force_off with pointer retained.
    reset_dut(4'b1111);
    @(negedge clk);
    chk("all_c1_lamp", int'(lamp), 4'b0001);
    chk("all_c1_wait", int'(waiting), 4'b1110);
    @(negedge clk);
    chk("all_c2_lamp", int'(lamp), 4'b0011);
    chk("all_c2_wait", int'(waiting), 4'b1100);
    chk("all_c2_busy", int'(busy), 1);
    repeat (5) @(negedge clk);
    chk("all_hold_lamp", int'(lamp), 4'b0011);
    chk("all_hold_busy", int'(busy), 1);
    force_off = 1'b1;
    @(negedge clk);
    chk("force_lamp", int'(lamp), 0);
    chk("force_wait", int'(waiting), 0);
    force_off = 1'b0;
    @(negedge clk);
    chk("force_next_grant", int'(lamp), 4'b0100);
    @(negedge clk);
    chk("force_second_grant", int'(lamp), 4'b1100);

    // Handover: zone 0 expires, zone 2 takes its slot one cycle later.
    reset_dut(4'b0011);
    repeat (2) @(negedge clk);
    chk("hand_start_lamp", int'(lamp), 4'b0011);
    req = 4'b0111;
    repeat (3) @(negedge clk);
    chk("hand_wait", int'(waiting), 4'b0100);
    req  = 4'b0110;
    fall = -1;
    rise = -1;
    over = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ($countones(lamp) > MAXON) over++;
      if (fall < 0 && !lamp[0]) fall = c;
      if (rise < 0 && lamp[2]) rise = c;
    end
    chk("hand_off_cycle", fall, HOLD - 1);
    chk("hand_gap", rise - fall, 1);
    chk("hand_never_three", over, 0);

    // Periodic re-trigger keeps zone 0 lit continuously.
    reset_dut('0);
    lows  = 0;
    highs = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 49 && !lamp[0]) lows++;
      if (c >= 50 && lamp[0]) highs++;
      if (c < 50 && (c % 7) == 0) req = 4'b0001;
      else req = '0;
    end
    chk("retrig_no_gap", lows, 0);
    chk("retrig_tail", highs, HOLD);

    // Asynchronous reset between edges, then restart search at zone 0.
    reset_dut(4'b1111);
    repeat (2) @(negedge clk);
    chk("arst_pre_lamp", int'(lamp), 4'b0011);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_lamp", int'(lamp), 0);
    chk("arst_wait", int'(waiting), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    req = 4'b0110;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_first_grant", int'(lamp), 4'b0010);
    @(negedge clk);
    chk("arst_second_grant", int'(lamp), 4'b0110);

    // Random soak against the model.
    reset_dut('0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int z = 0; z < N; z++) begin
        if ($urandom_range(0, 5) == 0) req[z] = ~req[z];
      end
      force_off = ($urandom_range(0, 79) == 0);
    end
    force_off = 1'b0;
    req       = '0;
    repeat (HOLD + 4) @(negedge clk);
    chk("soak_idle_lamp", int'(lamp), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
